// File: rtl/piano_pkg.sv
// Shared definitions for the piano note path: recorder states, the silence
// message and the layout of one recorded entry.
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  localparam logic [7:0] MSG_OFF = 8'h00;
  localparam int MSG_W   = 8;
  localparam int DELTA_W = 16;
  localparam int ENTRY_W = MSG_W + DELTA_W;

  typedef struct packed {
    logic [MSG_W-1:0]   msg;
    logic [DELTA_W-1:0] delta;
  } entry_t;

  function automatic logic [DELTA_W-1:0] sat_inc(input logic [DELTA_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Note message bus between keyboard, recorder and player, plus mode controls.
interface note_recorder_if;
  // in_valid/out_valid are one-cycle strobes with no back-pressure: the
  // message beside a strobe is taken in that cycle, and out_msg holds its
  // value until the next out_valid.
  logic       rec;
  logic       play;
  logic       in_valid;
  logic [7:0] in_msg;
  logic       out_valid;
  logic [7:0] out_msg;
  logic       recording;
  logic       playing;
  logic       full;

  modport slave (
    input  rec, play, in_valid, in_msg,
    output out_valid, out_msg, recording, playing, full
  );

  modport master (
    output rec, play, in_valid, in_msg,
    input  out_valid, out_msg, recording, playing, full
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks; clr restarts the
// count so the first tick lands DIV cycles after the clear.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);
endmodule

// File: rtl/note_recorder.sv
// Record/replay stage: passes live notes through, timestamps them into a
// buffer while recording, and replays them with the recorded spacing.
module note_recorder
  import piano_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int TICK_HZ  = 100,
  parameter int DEPTH    = 256
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  note_recorder_if.slave         bus,
  output state_t                 dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  state_t state, state_d;
  logic rec_q, play_q;
  logic rec_rise, rec_fall, play_rise, play_fall;
  logic enter_rec, enter_play, stop_play, emit, store, tick;

  logic [CNT_W-1:0]   count;
  logic [AW-1:0]      idx, idx_d, rd_addr;
  logic [DELTA_W-1:0] delta, cd;
  logic [MSG_W-1:0]   cur_msg;
  logic               last_done;
  logic               full_q;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] mem [DEPTH];
  entry_t             rd_data;

  assign rec_rise  =  bus.rec  & ~rec_q;
  assign rec_fall  = ~bus.rec  &  rec_q;
  assign play_rise =  bus.play & ~play_q;
  assign play_fall = ~bus.play &  play_q;

  tick_gen #(.DIV(CLK_FREQ / TICK_HZ)) u_tick (
    .clk   (pclk),
    .rst_n (rst_n),
    .clr   (enter_rec | enter_play),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state;
    enter_rec  = 1'b0;
    enter_play = 1'b0;
    stop_play  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rec_rise) begin
          state_d   = ST_REC;
          enter_rec = 1'b1;
        end else if (play_rise && count != '0) begin
          state_d    = ST_PLAY;
          enter_play = 1'b1;
        end
      end
      ST_REC: begin
        if (rec_fall) state_d = ST_IDLE;
      end
      ST_PLAY: begin
        if (play_fall || rec_rise || last_done) begin
          state_d   = ST_IDLE;
          stop_play = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign emit  = (state == ST_PLAY) && !stop_play && !last_done && (cd == '0);
  assign store = (state == ST_REC) && bus.in_valid && (count < CNT_W'(DEPTH));

  // The tick landing on the store edge belongs to this entry, not the next.
  assign wr_data = {bus.in_msg, tick ? sat_inc(delta) : delta};

  always_comb begin
    idx_d = idx;
    if (enter_play) idx_d = '0;
    else if (emit)  idx_d = idx + AW'(1);
  end

  // Read one entry ahead of the one being counted down, so an emission can
  // load the following delta and message in the same cycle.
  always_comb begin
    rd_addr = '0;
    if (enter_play || (state == ST_PLAY && !stop_play)) rd_addr = idx_d + AW'(1);
  end

  always_ff @(posedge pclk) begin
    if (store) mem[count[AW-1:0]] <= wr_data;
    if (store && count[AW-1:0] == rd_addr) rd_data <= entry_t'(wr_data);
    else                                    rd_data <= entry_t'(mem[rd_addr]);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rec_q         <= 1'b0;
      play_q        <= 1'b0;
      count         <= '0;
      idx           <= '0;
      delta         <= '0;
      cd            <= '0;
      cur_msg       <= MSG_OFF;
      last_done     <= 1'b0;
      full_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_msg   <= MSG_OFF;
      bus.recording <= 1'b0;
      bus.playing   <= 1'b0;
    end else begin
      state         <= state_d;
      rec_q         <= bus.rec;
      play_q        <= bus.play;
      idx           <= idx_d;
      bus.recording <= (state_d == ST_REC);
      bus.playing   <= (state_d == ST_PLAY);

      if (enter_rec) begin
        count  <= '0;
        full_q <= 1'b0;
        delta  <= '0;
      end else if (state == ST_REC) begin
        if (store) begin
          count <= count + CNT_W'(1);
          delta <= '0;
          if (count == CNT_W'(DEPTH - 1)) full_q <= 1'b1;
        end else if (tick) begin
          delta <= sat_inc(delta);
        end
      end

      if (enter_play) begin
        cd        <= rd_data.delta;
        cur_msg   <= rd_data.msg;
        last_done <= 1'b0;
      end else if (state == ST_PLAY) begin
        if (emit) begin
          cd      <= rd_data.delta;
          cur_msg <= rd_data.msg;
          if (CNT_W'(idx) + CNT_W'(1) == count) last_done <= 1'b1;
        end else if (tick && cd != '0) begin
          cd <= cd - 1'b1;
        end
      end

      bus.out_valid <= 1'b0;
      if (state != ST_PLAY) begin
        bus.out_valid <= bus.in_valid;
        if (bus.in_valid) bus.out_msg <= bus.in_msg;
      end else if (stop_play) begin
        bus.out_valid <= 1'b1;
        bus.out_msg   <= MSG_OFF;
      end else if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_msg   <= cur_msg;
      end
    end
  end

  assign bus.full  = full_q;
  assign dbg_state = state;
  assign dbg_count = count;
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with a timestamp/replay model and a
// per-cycle output scoreboard.
module tb_note_recorder;
  import piano_pkg::*;

  localparam int TICK  = 10;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  note_recorder_if bus();
  state_t     dbg_state;
  logic [2:0] dbg_count;

  note_recorder #(.CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(DEPTH)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  // Each expected message has either an absolute cycle (d = -1) or a tick
  // count d measured from the previous emission (or from PLAY entry).
  logic [7:0] exp_q[$];
  int         exp_d_q[$];
  int         exp_t_q[$];
  int         ref_cyc = 0;

  // Recording model: what the buffer must hold, from event times alone.
  bit         rec_on = 1'b0;
  int         rec_t0 = 0;
  int         m_t[$];
  logic [7:0] m_msg[$];
  int         m_delta[$];

  function automatic void flush_exp();
    exp_q.delete();
    exp_d_q.delete();
    exp_t_q.delete();
  endfunction

  function automatic void push_exp(input logic [7:0] m, input int d, input int t);
    exp_q.push_back(m);
    exp_d_q.push_back(d);
    exp_t_q.push_back(t);
  endfunction

  always @(negedge pclk) begin : cmp
    int lo, hi;
    if (rst_n) begin
      lo = 0;
      hi = 0;
      if (exp_q.size() > 0) begin
        if (exp_d_q[0] < 0) begin
          lo = exp_t_q[0];
          hi = exp_t_q[0];
        end else if (exp_d_q[0] == 0) begin
          lo = ref_cyc + 1;
          hi = ref_cyc + 1;
        end else begin
          lo = ref_cyc + TICK * exp_d_q[0] - 1;
          hi = ref_cyc + TICK * exp_d_q[0] + 1;
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: out_msg=%02h at cycle %0d, required no output", bus.out_msg, cyc);
        end else begin
          if (bus.out_msg !== exp_q[0] || cyc < lo || cyc > hi) begin
            errors++;
            $display("FAIL out_stream: out_msg=%02h at cycle %0d, required %02h in cycles %0d..%0d",
                     bus.out_msg, cyc, exp_q[0], lo, hi);
          end
          ref_cyc = cyc;
          void'(exp_q.pop_front());
          void'(exp_d_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end else if (exp_q.size() > 0 && cyc > hi) begin
        checks++;
        errors++;
        $display("FAIL missing_out: nothing by cycle %0d, required %02h in cycles %0d..%0d",
                 cyc, exp_q[0], lo, hi);
        void'(exp_q.pop_front());
        void'(exp_d_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic send(input logic [7:0] m, input bit pass);
    int n, prev;
    n = cyc + 1;
    bus.in_valid = 1'b1;
    bus.in_msg   = m;
    if (pass) push_exp(m, -1, n);
    if (rec_on && m_msg.size() < DEPTH) begin
      prev = (m_t.size() == 0) ? rec_t0 : m_t[m_t.size()-1];
      m_delta.push_back((n - rec_t0) / TICK - (prev - rec_t0) / TICK);
      m_t.push_back(n);
      m_msg.push_back(m);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_rec(input bit v);
    if (v && !bus.rec) begin
      rec_on = 1'b1;
      rec_t0 = cyc + 1;
      m_t.delete();
      m_msg.delete();
      m_delta.delete();
    end
    if (!v) rec_on = 1'b0;
    bus.rec = v;
    step();
  endtask

  task automatic start_play();
    bus.play = 1'b1;
    ref_cyc  = cyc + 1;
    for (int i = 0; i < m_msg.size(); i++) push_exp(m_msg[i], m_delta[i], 0);
    push_exp(MSG_OFF, 0, 0);
    step();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d outputs pending after %0d cycles, required 0", name, exp_q.size(), budget);
      flush_exp();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, f;
    bus.rec = 1'b0;
    bus.play = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_msg = 8'h00;
    repeat (3) @(negedge pclk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_msg",   32'(bus.out_msg),   32'h00);
    check("rst_recording", 32'(bus.recording), 32'd0);
    check("rst_playing",   32'(bus.playing),   32'd0);
    check("rst_full",      32'(bus.full),      32'd0);
    check("rst_state",     32'(dbg_state),     32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) step();

    // Empty buffer: play rise is ignored.
    bus.play = 1'b1;
    repeat (4) step();
    check("empty_play_playing", 32'(bus.playing), 32'd0);
    check("empty_play_state",   32'(dbg_state),   32'(ST_IDLE));
    bus.play = 1'b0;
    step();

    // Idle passthrough.
    send(8'h85, 1'b1);
    check("pass_recording", 32'(bus.recording), 32'd0);
    check("pass_playing",   32'(bus.playing),   32'd0);
    send(8'h3c, 1'b1);
    drain("pass", 5);

    // Simultaneous rise: record wins; play edges are ignored in REC.
    bus.play = 1'b1;
    set_rec(1'b1);
    check("collide_recording", 32'(bus.recording), 32'd1);
    check("collide_playing",   32'(bus.playing),   32'd0);
    bus.play = 1'b0;
    step();
    check("rec_ignores_play", 32'(bus.recording), 32'd1);
    set_rec(1'b0);
    check("rec_fall_idle", 32'(bus.recording), 32'd0);
    check("collide_count", 32'(dbg_count), 32'd0);

    // Record two events 30 and 80 cycles after REC entry, then replay.
    set_rec(1'b1);
    wait_until(rec_t0 + 29);
    send(8'h85, 1'b1);
    wait_until(rec_t0 + 79);
    send(8'h00, 1'b1);
    set_rec(1'b0);
    drain("rec_pass", 5);
    check("rr_count",  32'(dbg_count), 32'd2);
    check("rr_full",   32'(bus.full),  32'd0);
    check("rr_model_d0", 32'(m_delta[0]), 32'd3);
    check("rr_model_d1", 32'(m_delta[1]), 32'd5);
    start_play();
    check("rr_playing", 32'(bus.playing), 32'd1);
    drain("replay", 150);
    check("rr_play_done", 32'(bus.playing), 32'd0);
    bus.play = 1'b0;
    step();

    // Five events into a four-entry buffer.
    set_rec(1'b1);
    wait_until(rec_t0 + 11); send(8'h90, 1'b1);
    wait_until(rec_t0 + 18); send(8'h91, 1'b1);
    wait_until(rec_t0 + 43); send(8'h12, 1'b1);
    check("full_before_last", 32'(bus.full), 32'd0);
    wait_until(rec_t0 + 46); send(8'h93, 1'b1);
    check("full_set", 32'(bus.full), 32'd1);
    wait_until(rec_t0 + 56); send(8'h94, 1'b1);
    set_rec(1'b0);
    drain("full_pass", 5);
    check("full_count", 32'(dbg_count), 32'd4);
    check("full_model_n", 32'(m_msg.size()), 32'd4);
    check("full_model_d", {8'(m_delta[0]), 8'(m_delta[1]), 8'(m_delta[2]), 8'(m_delta[3])}, 32'h01000300);
    start_play();
    drain("full_replay", 100);
    check("full_after_play", 32'(bus.full), 32'd1);
    bus.play = 1'b0;
    step();

    // Abort mid-playback; live input during PLAY must not appear.
    set_rec(1'b1);
    wait_until(rec_t0 + 39); send(8'h81, 1'b1);
    wait_until(rec_t0 + 79); send(8'h82, 1'b1);
    wait_until(rec_t0 + 84); send(8'h83, 1'b1);
    set_rec(1'b0);
    drain("abort_pass", 5);
    check("abort_full_cleared", 32'(bus.full), 32'd0);
    start_play();
    p0 = ref_cyc;
    wait_until(p0 + 20);
    send(8'h7f, 1'b0);
    wait_until(p0 + 60);
    check("abort_first_out", 32'(exp_q.size()), 32'd3);
    f = cyc + 1;
    flush_exp();
    push_exp(MSG_OFF, -1, f);
    bus.play = 1'b0;
    step();
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    send(8'h7e, 1'b1);
    drain("abort", 10);
    check("abort_playing", 32'(bus.playing), 32'd0);
    check("abort_count",   32'(dbg_count),   32'd3);

    // Asynchronous reset in the middle of a full recording.
    set_rec(1'b1);
    send(8'hc1, 1'b1);
    send(8'hc2, 1'b1);
    send(8'hc3, 1'b1);
    send(8'hc4, 1'b1);
    drain("rst_pass", 5);
    check("rst_pre_full", 32'(bus.full), 32'd1);
    @(posedge pclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_msg",   32'(bus.out_msg),   32'h00);
    check("arst_recording", 32'(bus.recording), 32'd0);
    check("arst_full",      32'(bus.full),      32'd0);
    check("arst_count",     32'(dbg_count),     32'd0);
    bus.rec = 1'b0;
    rec_on = 1'b0;
    flush_exp();
    repeat (2) @(negedge pclk);
    #1;
    rst_n = 1'b1;
    step();
    bus.play = 1'b1;
    repeat (5) step();
    check("post_rst_playing", 32'(bus.playing), 32'd0);
    check("post_rst_state",   32'(dbg_state),   32'(ST_IDLE));
    bus.play = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
